// File: rtl/bp_cce_lce_req_rx.sv
// CCE-side receiver for LCE request messages: buffers NoC requests, steers cached and
// uncached traffic to separate consumers, and polices per-LCE outstanding-request credits.
module bp_cce_lce_req_rx
    #(parameter int num_lce_p      = 4,
      parameter int fifo_els_p     = 2,
      parameter int credits_p      = 4,
      parameter int lce_id_width_p = 3,
      parameter int paddr_width_p  = 40,
      parameter int lce_assoc_p    = 8,
      parameter int dword_width_p  = 64,
      localparam int way_id_width_lp = $clog2(lce_assoc_p),
      localparam int lce_cce_req_header_width_lp =
          3 + way_id_width_lp + paddr_width_p + lce_id_width_p + 3,
      localparam int lce_cce_req_width_lp = lce_cce_req_header_width_lp + dword_width_p)
    (input  logic                                   clk_i,
     input  logic                                   reset_n_i,
     input  logic [lce_cce_req_width_lp-1:0]        lce_req_i,
     input  logic                                   lce_req_v_i,
     output logic                                   lce_req_ready_o,
     output logic [lce_cce_req_header_width_lp-1:0] cached_req_o,
     output logic                                   cached_req_v_o,
     input  logic                                   cached_req_yumi_i,
     output logic [lce_cce_req_width_lp-1:0]        uc_req_o,
     output logic                                   uc_req_v_o,
     input  logic                                   uc_req_yumi_i,
     input  logic                                   done_v_i,
     input  logic [lce_id_width_p-1:0]              done_lce_i,
     output logic [num_lce_p-1:0]                   pending_o,
     output logic                                   error_o);

    typedef enum logic [2:0] {
        e_lce_req_type_rd    = 3'd0,
        e_lce_req_type_wr    = 3'd1,
        e_lce_req_type_uc_rd = 3'd2,
        e_lce_req_type_uc_wr = 3'd3
    } bp_lce_cce_req_type_e;

    typedef struct packed {
        logic [2:0]                  size;
        logic [way_id_width_lp-1:0]  lru_way_id;
        logic [paddr_width_p-1:0]    addr;
        logic [lce_id_width_p-1:0]   src_id;
        bp_lce_cce_req_type_e        msg_type;
    } bp_lce_cce_req_header_s;

    typedef struct packed {
        logic [dword_width_p-1:0] data;
        bp_lce_cce_req_header_s   header;
    } bp_lce_cce_req_s;

    typedef enum logic [1:0] {e_reset, e_ready, e_error} state_e;

    localparam int ptr_width_lp    = $clog2(fifo_els_p);
    localparam int cnt_width_lp    = $clog2(fifo_els_p + 1);
    localparam int credit_width_lp = $clog2(credits_p + 1);

    state_e                     state_r;
    logic                       error_r;
    bp_lce_cce_req_s            mem_r [fifo_els_p];
    logic [ptr_width_lp-1:0]    wr_ptr_r, rd_ptr_r;
    logic [cnt_width_lp-1:0]    fifo_cnt_r;
    logic [credit_width_lp-1:0] count_r [num_lce_p];
    logic [credit_width_lp-1:0] count_n [num_lce_p];
    logic [num_lce_p-1:0]       pending_r, pending_n;

    bp_lce_cce_req_s head;
    logic fifo_empty, fifo_full, ready, enq, deq, good_deq;
    logic head_live, head_cached, head_uc, src_ok, drop;
    logic cached_v, uc_v, yumi_err, credit_err, done_bad, err_now;

    assign head       = mem_r[rd_ptr_r];
    assign fifo_empty = (fifo_cnt_r == '0);
    assign fifo_full  = (fifo_cnt_r == cnt_width_lp'(fifo_els_p));

    // Ready looks only at the registered occupancy, so a full buffer stalls
    // the NoC for one cycle even when the head leaves in the same cycle.
    assign ready = (state_r == e_ready) & ~fifo_full;
    assign enq   = lce_req_v_i & ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        head_cached = 1'b0;
        head_uc     = 1'b0;
        case (head.header.msg_type)
            e_lce_req_type_rd, e_lce_req_type_wr:       head_cached = 1'b1;
            e_lce_req_type_uc_rd, e_lce_req_type_uc_wr: head_uc     = 1'b1;
            default: ;
        endcase
    end

    assign src_ok    = int'(head.header.src_id) < num_lce_p;
    assign head_live = (state_r == e_ready) & ~fifo_empty;
    assign cached_v  = head_live & head_cached & src_ok;
    assign uc_v      = head_live & head_uc & src_ok;
    // A malformed head is discarded so it cannot wedge the buffer.
    assign drop      = head_live & ~(cached_v | uc_v);
    assign good_deq  = (cached_v & cached_req_yumi_i) | (uc_v & uc_req_yumi_i);
    assign deq       = good_deq | drop;
    assign yumi_err  = (cached_req_yumi_i & ~cached_v) | (uc_req_yumi_i & ~uc_v);
    assign done_bad  = done_v_i & (int'(done_lce_i) >= num_lce_p);
    assign err_now   = drop | yumi_err | credit_err | done_bad;

    always_comb begin
        credit_err = 1'b0;
        for (int i = 0; i < num_lce_p; i++) begin
            logic inc, dec;
            inc = good_deq & (int'(head.header.src_id) == i);
            dec = done_v_i & (int'(done_lce_i) == i);
            count_n[i] = count_r[i];
            if (inc & ~dec) begin
                if (count_r[i] == credit_width_lp'(credits_p))
                    credit_err = 1'b1;
                else
                    count_n[i] = count_r[i] + credit_width_lp'(1);
            end else if (dec & ~inc) begin
                if (count_r[i] == '0)
                    credit_err = 1'b1;
                else
                    count_n[i] = count_r[i] - credit_width_lp'(1);
            end
            pending_n[i] = (count_n[i] != '0);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_reset;
            error_r <= 1'b0;
        end else begin
            if (err_now)
                error_r <= 1'b1;
            case (state_r)
                e_reset: state_r <= err_now ? e_error : e_ready;
                e_ready: if (err_now) state_r <= e_error;
                default: state_r <= e_error;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            pending_r  <= '0;
            for (int i = 0; i < num_lce_p; i++)
                count_r[i] <= '0;
        end else begin
            if (enq)
                wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(fifo_els_p - 1))
                            ? '0 : wr_ptr_r + ptr_width_lp'(1);
            if (deq)
                rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(fifo_els_p - 1))
                            ? '0 : rd_ptr_r + ptr_width_lp'(1);
            if (enq & ~deq)
                fifo_cnt_r <= fifo_cnt_r + cnt_width_lp'(1);
            else if (deq & ~enq)
                fifo_cnt_r <= fifo_cnt_r - cnt_width_lp'(1);
            pending_r <= pending_n;
            for (int i = 0; i < num_lce_p; i++)
                count_r[i] <= count_n[i];
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after the pointers mark it written.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wr_ptr_r] <= bp_lce_cce_req_s'(lce_req_i);
    end

    assign lce_req_ready_o = ready;
    assign cached_req_v_o  = cached_v;
    assign uc_req_v_o      = uc_v;
    assign cached_req_o    = cached_v ? head.header : '0;
    assign uc_req_o        = uc_v ? head : '0;
    assign pending_o       = pending_r;
    assign error_o         = error_r;

endmodule

// File: tb/tb_bp_cce_lce_req_rx.sv
// Bench for bp_cce_lce_req_rx: directed scenarios plus randomized traffic checked by a
// queue-based scoreboard and a per-LCE outstanding-count model.
module tb_bp_cce_lce_req_rx;

    localparam int num_lce_p      = 4;
    localparam int fifo_els_p     = 2;
    localparam int credits_p      = 4;
    localparam int lce_id_width_p = 3;
    localparam int paddr_width_p  = 40;
    localparam int lce_assoc_p    = 8;
    localparam int dword_width_p  = 64;
    localparam int way_w          = $clog2(lce_assoc_p);
    localparam int hdr_w          = 3 + way_w + paddr_width_p + lce_id_width_p + 3;
    localparam int msg_w          = hdr_w + dword_width_p;

    localparam logic [2:0] RD = 3'd0, WR = 3'd1, UC_RD = 3'd2, UC_WR = 3'd3;

    logic                      clk_i = 1'b0;
    logic                      reset_n_i = 1'b0;
    logic [msg_w-1:0]          lce_req_i = '0;
    logic                      lce_req_v_i = 1'b0;
    logic                      lce_req_ready_o;
    logic [hdr_w-1:0]          cached_req_o;
    logic                      cached_req_v_o;
    logic                      cached_req_yumi_i = 1'b0;
    logic [msg_w-1:0]          uc_req_o;
    logic                      uc_req_v_o;
    logic                      uc_req_yumi_i = 1'b0;
    logic                      done_v_i = 1'b0;
    logic [lce_id_width_p-1:0] done_lce_i = '0;
    logic [num_lce_p-1:0]      pending_o;
    logic                      error_o;

    bp_cce_lce_req_rx dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .lce_req_i         (lce_req_i),
        .lce_req_v_i       (lce_req_v_i),
        .lce_req_ready_o   (lce_req_ready_o),
        .cached_req_o      (cached_req_o),
        .cached_req_v_o    (cached_req_v_o),
        .cached_req_yumi_i (cached_req_yumi_i),
        .uc_req_o          (uc_req_o),
        .uc_req_v_o        (uc_req_v_o),
        .uc_req_yumi_i     (uc_req_yumi_i),
        .done_v_i          (done_v_i),
        .done_lce_i        (done_lce_i),
        .pending_o         (pending_o),
        .error_o           (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit               is_uc;
        logic [msg_w-1:0] msg;
    } exp_t;

    exp_t exp_q[$];
    int   mcnt[num_lce_p];
    int   inflight[num_lce_p];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [msg_w-1:0] make_msg(input logic [2:0] t, input int src,
                                                 input logic [paddr_width_p-1:0] addr,
                                                 input logic [dword_width_p-1:0] data);
        logic [way_w-1:0] way;
        way = way_w'($urandom_range(lce_assoc_p - 1));
        return {data, 3'd3, way, addr, lce_id_width_p'(src), t};
    endfunction

    // Monitor: compares whatever the DUT presents against the head of the
    // scoreboard and keeps the outstanding-count model in step with handshakes.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_lce_p; i++) mcnt[i] = 0;
        end else begin
            logic [num_lce_p-1:0] exp_pend;
            int src;
            bit hs;
            for (int i = 0; i < num_lce_p; i++) exp_pend[i] = (mcnt[i] != 0);
            check("pending", 128'(pending_o), 128'(exp_pend));
            src = -1;
            if (cached_req_v_o || uc_req_v_o) begin
                check("one_valid", 128'(cached_req_v_o & uc_req_v_o), 128'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'(1), 128'(0));
                end else begin
                    check("port_kind", 128'(uc_req_v_o), 128'(exp_q[0].is_uc));
                    if (uc_req_v_o)
                        check("uc_payload", 128'(uc_req_o), 128'(exp_q[0].msg));
                    else
                        check("cached_payload", 128'(cached_req_o), 128'(exp_q[0].msg[hdr_w-1:0]));
                    hs = (uc_req_v_o & uc_req_yumi_i) | (cached_req_v_o & cached_req_yumi_i);
                    if (hs) begin
                        src = int'(exp_q[0].msg[3 +: lce_id_width_p]);
                        void'(exp_q.pop_front());
                    end
                end
            end
            for (int i = 0; i < num_lce_p; i++) begin
                bit inc, dec;
                inc = (src == i);
                dec = done_v_i && (int'(done_lce_i) == i);
                if (inc && !dec) mcnt[i] = (mcnt[i] < credits_p) ? mcnt[i] + 1 : credits_p;
                else if (dec && !inc) mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        lce_req_v_i       = 1'b0;
        cached_req_yumi_i = 1'b0;
        uc_req_yumi_i     = 1'b0;
        done_v_i          = 1'b0;
    endtask

    task automatic send_msg(input logic [msg_w-1:0] m, input bit push);
        int src;
        logic [2:0] t;
        t   = m[2:0];
        src = int'(m[3 +: lce_id_width_p]);
        lce_req_i   = m;
        lce_req_v_i = 1'b1;
        if (push && t <= UC_WR && src < num_lce_p) begin
            exp_q.push_back('{is_uc: (t == UC_RD || t == UC_WR), msg: m});
            inflight[src]++;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < num_lce_p; i++) inflight[i] = 0;
    endtask

    task automatic release_reset();
        reset_n_i = 1'b1;
        #1;
        check("release_ready_low", 128'(lce_req_ready_o), 128'(0));
        tick();
        check("ready_after_reset", 128'(lce_req_ready_o), 128'(1));
        check("pending_after_reset", 128'(pending_o), 128'(0));
        check("error_after_reset", 128'(error_o), 128'(0));
        check("valids_after_reset", 128'({cached_req_v_o, uc_req_v_o}), 128'(0));
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        release_reset();
    endtask

    task automatic drain();
        int  budget;
        bit  busy;
        budget = 0;
        busy   = 1'b1;
        while (busy && budget < 500) begin
            cached_req_yumi_i = cached_req_v_o;
            uc_req_yumi_i     = uc_req_v_o;
            for (int l = 0; l < num_lce_p; l++)
                if (!done_v_i && mcnt[l] > 0) begin
                    done_v_i   = 1'b1;
                    done_lce_i = lce_id_width_p'(l);
                    inflight[l]--;
                end
            tick();
            budget++;
            busy = (exp_q.size() != 0);
            for (int l = 0; l < num_lce_p; l++) if (mcnt[l] != 0) busy = 1'b1;
        end
        check("drain_complete", 128'(busy), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [msg_w-1:0] m, m2;
        int src;

        // Reset: all outputs low while asserted
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_outputs", 128'({lce_req_ready_o, cached_req_v_o, uc_req_v_o, pending_o, error_o}), 128'(0));
        check("rst_payloads", 128'(cached_req_o) | 128'(uc_req_o), 128'(0));
        release_reset();

        // Single cached read from LCE 2
        m = make_msg(RD, 2, 40'h00_8000_0040, 64'h0);
        send_msg(m, 1'b1);
        tick();
        check("rd_valid_n1", 128'({cached_req_v_o, uc_req_v_o}), 128'(2'b10));
        check("rd_header_n1", 128'(cached_req_o), 128'(m[hdr_w-1:0]));
        tick();
        check("rd_valid_held", 128'(cached_req_v_o), 128'(1));
        cached_req_yumi_i = 1'b1;
        tick();
        check("rd_pending", 128'(pending_o), 128'(4'b0100));
        check("rd_consumed", 128'(cached_req_v_o), 128'(0));
        done_v_i = 1'b1; done_lce_i = 3'd2; inflight[2]--;
        tick();
        check("rd_done_pending", 128'(pending_o), 128'(0));
        check("rd_no_error", 128'(error_o), 128'(0));

        // uc_wr then wr back-to-back with yumi held low: order and data preserved
        m = make_msg(UC_WR, 1, 40'h00_0000_1000, 64'h0000_0000_DEAD_BEEF);
        send_msg(m, 1'b1);
        tick();
        m2 = make_msg(WR, 3, 40'h00_0000_2040, 64'h0);
        send_msg(m2, 1'b1);
        tick();
        check("ucwr_first", 128'({cached_req_v_o, uc_req_v_o}), 128'(2'b01));
        check("ucwr_data", 128'(uc_req_o[hdr_w +: dword_width_p]), 128'(64'hDEAD_BEEF));
        check("full_ready_low", 128'(lce_req_ready_o), 128'(0));
        tick();
        check("full_ready_still_low", 128'(lce_req_ready_o), 128'(0));
        uc_req_yumi_i = 1'b1;
        tick();
        check("ready_returns", 128'(lce_req_ready_o), 128'(1));
        check("wr_follows", 128'({cached_req_v_o, uc_req_v_o}), 128'(2'b10));
        check("wr_header", 128'(cached_req_o), 128'(m2[hdr_w-1:0]));
        drain();

        // Generic fill to depth, release one slot, nothing lost
        for (int k = 0; k < fifo_els_p; k++) begin
            send_msg(make_msg(3'($urandom_range(3)), k % num_lce_p, 40'($urandom()), {$urandom(), $urandom()}), 1'b1);
            tick();
        end
        check("fill_ready_low", 128'(lce_req_ready_o), 128'(0));
        cached_req_yumi_i = cached_req_v_o;
        uc_req_yumi_i     = uc_req_v_o;
        tick();
        check("fill_ready_back", 128'(lce_req_ready_o), 128'(1));
        drain();

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 1500; c++) begin
            if (lce_req_ready_o && $urandom_range(99) < 60) begin
                src = int'($urandom_range(num_lce_p - 1));
                if (inflight[src] < credits_p)
                    send_msg(make_msg(3'($urandom_range(3)), src, 40'($urandom()),
                                      {$urandom(), $urandom()}), 1'b1);
            end
            if (cached_req_v_o && $urandom_range(99) < 60) cached_req_yumi_i = 1'b1;
            if (uc_req_v_o && $urandom_range(99) < 60) uc_req_yumi_i = 1'b1;
            src = int'($urandom_range(num_lce_p - 1));
            if (mcnt[src] > 0 && $urandom_range(99) < 35) begin
                done_v_i   = 1'b1;
                done_lce_i = lce_id_width_p'(src);
                inflight[src]--;
            end
            tick();
        end
        drain();
        check("random_no_error", 128'(error_o), 128'(0));

        // Credit overflow on LCE 0; a second request left behind in the buffer
        do_reset();
        for (int k = 0; k <= credits_p; k++) begin
            send_msg(make_msg(RD, 0, 40'($urandom()), 64'h0), 1'b1);
            tick();
            if (k == credits_p) send_msg(make_msg(WR, 1, 40'($urandom()), 64'h0), 1'b1);
            check("ovf_no_error_yet", 128'(error_o), 128'(0));
            cached_req_yumi_i = 1'b1;
            tick();
        end
        check("ovf_error", 128'(error_o), 128'(1));
        check("ovf_ready_low", 128'(lce_req_ready_o), 128'(0));
        check("ovf_valids_low", 128'({cached_req_v_o, uc_req_v_o}), 128'(0));
        tick(); tick();
        check("ovf_error_sticky", 128'({error_o, lce_req_ready_o, cached_req_v_o, uc_req_v_o}), 128'(4'b1000));

        // Other error sources: bad type, bad src_id, stray yumi, done underflow
        for (int kind = 0; kind < 4; kind++) begin
            do_reset();
            case (kind)
                0: send_msg(make_msg(3'd5, 1, 40'h40, 64'h0), 1'b0);
                1: send_msg(make_msg(RD, 5, 40'h40, 64'h0), 1'b0);
                2: cached_req_yumi_i = 1'b1;
                default: begin done_v_i = 1'b1; done_lce_i = 3'd1; end
            endcase
            tick();
            if (kind < 2) begin
                check($sformatf("err%0d_no_valid", kind), 128'({cached_req_v_o, uc_req_v_o}), 128'(0));
                tick();
            end
            check($sformatf("err%0d_error", kind), 128'(error_o), 128'(1));
            check($sformatf("err%0d_ready", kind), 128'(lce_req_ready_o), 128'(0));
        end

        // Asynchronous reset in the middle of traffic
        do_reset();
        send_msg(make_msg(RD, 2, 40'h80, 64'h0), 1'b1);
        tick();
        cached_req_yumi_i = 1'b1;
        send_msg(make_msg(UC_RD, 1, 40'hC0, 64'h0), 1'b1);
        tick();
        send_msg(make_msg(WR, 3, 40'h100, 64'h0), 1'b1);
        tick();
        check("mid_pending", 128'(pending_o), 128'(4'b0100));
        check("mid_full", 128'(lce_req_ready_o), 128'(0));
        #2 reset_n_i = 1'b0;
        #1;
        check("async_rst_outputs", 128'({lce_req_ready_o, cached_req_v_o, uc_req_v_o, pending_o, error_o}), 128'(0));
        clear_model();
        @(posedge clk_i);
        #1;
        release_reset();
        tick();
        check("mid_fifo_empty", 128'({cached_req_v_o, uc_req_v_o}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
